// File: rtl/square_restore.sv
// square_restore: rebuilds D = Q*Q + R from a root/remainder pair with a bit-serial shift-add multiplier
module square_restore #(
  parameter int d_width = 58,
  parameter int q_width = d_width/2-1,
  parameter int r_width = d_width/2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_vaild,
  output logic               i_ready,
  input  logic [q_width:0]   data_q,
  input  logic [r_width:0]   data_r,
  output logic               o_vaild,
  output logic [d_width-1:0] data_o,
  output logic               o_ovf,
  output logic               o_err
);
  localparam int n = d_width/2;
  localparam int cw = $clog2(n+1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [d_width:0] acc, mcand, acc_n;
  logic [q_width:0] mult;
  logic [cw-1:0] cnt;
  logic err_r, accept, last;
  assign accept = i_vaild & i_ready & (state == IDLE);
  assign last = cnt == cw'(n-1);
  always_comb begin
    state_n = state == IDLE ? (accept ? CALC : IDLE) : state == CALC ? (last ? DONE : CALC) : IDLE;
    acc_n = mult[0] ? acc + mcand : acc;
  end
  // the final partial product is folded in on the same edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i_ready <= 1'b0;
      o_vaild <= 1'b0;
      data_o  <= '0;
      o_ovf   <= 1'b0;
      o_err   <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mult    <= '0;
      cnt     <= '0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_n;
      i_ready <= state_n == IDLE;
      o_vaild <= 1'b0;
      if (accept) begin
        acc   <= {{(d_width-r_width){1'b0}}, data_r};
        mcand <= {{(d_width-q_width){1'b0}}, data_q};
        mult  <= data_q;
        cnt   <= '0;
        err_r <= data_r > {data_q, 1'b0};
      end
      if (state == CALC) begin
        acc   <= acc_n;
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        cnt   <= cnt + 1'b1;
        if (last) begin
          data_o  <= acc_n[d_width-1:0];
          o_ovf   <= acc_n[d_width];
          o_err   <= err_r;
          o_vaild <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_square_restore.sv
// tb_square_restore: scoreboard bench for square_restore at d_width=58
module tb_square_restore;
  localparam int D = 58;
  localparam int N = D/2;
  logic clk = 0, rst = 1, i_vaild = 0;
  logic [N-1:0] data_q = '0;
  logic [N:0] data_r = '0;
  logic i_ready, o_vaild, o_ovf, o_err;
  logic [D-1:0] data_o;
  logic [D+1:0] sb[$];
  int total = 0, bad = 0;

  square_restore #(.d_width(D)) dut (
    .clk(clk), .rst(rst), .i_vaild(i_vaild), .i_ready(i_ready),
    .data_q(data_q), .data_r(data_r), .o_vaild(o_vaild),
    .data_o(data_o), .o_ovf(o_ovf), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [D+1:0] model(longint unsigned q, longint unsigned r);
    longint unsigned full;
    full = q*q + r;
    return {full[D], r > 2*q, full[D-1:0]};
  endfunction

  function automatic longint unsigned isqrt(longint unsigned d);
    longint unsigned res, t;
    res = 0;
    for (int i = N-1; i >= 0; i--) begin
      t = res | (64'd1 << i);
      if (t*t <= d) res = t;
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (!rst && o_vaild) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_o_vaild: got data_o=%0h ovf=%0b err=%0b, expected no result", data_o, o_ovf, o_err);
      end else begin
        logic [D+1:0] e;
        e = sb.pop_front();
        if ({o_ovf, o_err, data_o} !== e)
          begin bad++; $display("FAIL result: got ovf=%0b err=%0b data_o=%0h, expected ovf=%0b err=%0b data_o=%0h", o_ovf, o_err, data_o, e[D+1], e[D], e[D-1:0]); end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!i_ready && k < 200) begin @(negedge clk); k++; end
    if (!i_ready) begin total++; bad++; $display("FAIL ready_timeout: i_ready=0 after 200 cycles, expected 1"); end
  endtask

  task automatic send(input logic [N-1:0] q, input logic [N:0] r, input bit expect_result);
    wait_ready();
    i_vaild = 1; data_q = q; data_r = r;
    if (expect_result) sb.push_back(model(q, r));
    @(posedge clk); #1 i_vaild = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 500) begin @(posedge clk); k++; end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL drain: %0d results outstanding, expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({i_ready, o_vaild, o_ovf, o_err, data_o} !== '0)
      begin bad++; $display("FAIL reset_state: got rdy=%0b vld=%0b ovf=%0b err=%0b data_o=%0h, expected all 0", i_ready, o_vaild, o_ovf, o_err, data_o); end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); @(negedge clk);
    total++;
    if (i_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %0b, expected 1", i_ready); end
  endtask

  task automatic test_latency();
    int k = 0, lows = 0;
    send('0, '0, 1);
    do begin
      @(posedge clk); k++; @(negedge clk);
      if (!i_ready) lows++;
    end while (!o_vaild && k < 100);
    total++;
    if (k != N) begin bad++; $display("FAIL latency: o_vaild after %0d edges, expected %0d", k, N); end
    total++;
    if (lows != N) begin bad++; $display("FAIL ready_low_calc: low %0d cycles, expected %0d", lows, N); end
    @(posedge clk); @(negedge clk);
    total++;
    if (o_vaild !== 1'b0 || i_ready !== 1'b1) begin bad++; $display("FAIL pulse_end: got vld=%0b rdy=%0b, expected vld=0 rdy=1", o_vaild, i_ready); end
    total++;
    if (data_o !== '0) begin bad++; $display("FAIL data_hold: got %0h, expected 0", data_o); end
  endtask

  task automatic test_basic();
    send(5, 3, 1);
    send(5, 11, 1);
    send(3, 6, 1);
    send(1000, 7, 1);
    drain();
  endtask

  task automatic test_boundary();
    send({N{1'b1}}, {{N{1'b1}}, 1'b0}, 1);
    send({N{1'b1}}, {(N+1){1'b1}}, 1);
    send('0, {(N+1){1'b1}}, 1);
    drain();
    total++;
    if ({o_ovf, o_err, data_o} !== {2'b01, {{(D-N-1){1'b0}}, {(N+1){1'b1}}}})
      begin bad++; $display("FAIL hold_after_pulse: got ovf=%0b err=%0b data_o=%0h", o_ovf, o_err, data_o); end
  endtask

  task automatic test_back_to_back();
    int last_acc = -1, lows = 0, accepts = 0;
    wait_ready();
    i_vaild = 1;
    data_q = N'($urandom); data_r = (N+1)'($urandom);
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (i_ready) begin
        sb.push_back(model(data_q, data_r));
        accepts++;
        if (last_acc >= 0) begin
          total++;
          if (c - last_acc != N+2 || lows != N+1)
            begin bad++; $display("FAIL b2b_spacing: gap=%0d low=%0d, expected gap=%0d low=%0d", c - last_acc, lows, N+2, N+1); end
        end
        last_acc = c; lows = 0;
      end else lows++;
      @(posedge clk); #1;
      data_q = N'($urandom); data_r = (N+1)'($urandom);
    end
    i_vaild = 0;
    total++;
    if (accepts != 4) begin bad++; $display("FAIL b2b_accepts: got %0d, expected 4", accepts); end
    drain();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    send(3, 1, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    total++;
    if (i_ready !== 1'b0) begin bad++; $display("FAIL ready_in_rst: got %0b, expected 0", i_ready); end
    @(posedge clk); @(negedge clk);
    total++;
    if (i_ready !== 1'b1) begin bad++; $display("FAIL ready_after_abort: got %0b, expected 1", i_ready); end
    repeat (40) begin @(negedge clk); if (o_vaild) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL aborted_output: got %0d pulses, expected 0", seen); end
    send(7, 0, 1);
    drain();
  endtask

  task automatic test_random();
    longint unsigned d, q, r;
    for (int i = 0; i < 300; i++) begin
      d = {$urandom, $urandom};
      d = d & ((64'd1 << D) - 1);
      q = isqrt(d);
      r = d - q*q;
      wait_ready();
      i_vaild = 1; data_q = N'(q); data_r = (N+1)'(r);
      sb.push_back({2'b00, d[D-1:0]});
      @(posedge clk); #1 i_vaild = 0;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
